// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for an 8-bit universal shift register.
// It accepts LOAD/SHL/SHR/LOAD_SHR commands and drives the register's control, serial and data pins.
`timescale 1ns/1ps
module shift_reg_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_rot,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             halt,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       reg_ctrl,
    output logic             reg_en,
    output logic             reg_s_in,
    output logic [WIDTH-1:0] reg_d,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_SHL      = 2'b01;
    localparam logic [1:0] OP_LOAD_SHR = 2'b11;

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHL  = 2'b01;
    localparam logic [1:0] CTRL_LOAD = 2'b10;
    localparam logic [1:0] CTRL_SHR  = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             rot_q, rot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             shl_dir;
    logic             out_bit;
    logic             unused_reg_q_mid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rot_q   <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Only SHL shifts toward the MSB; SHR and LOAD_SHR both shift toward the LSB.
    assign shl_dir = (op_q == OP_SHL);
    assign out_bit = shl_dir ? reg_q[WIDTH-1] : reg_q[0];

    assign unused_reg_q_mid = ^reg_q[WIDTH-2:1];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    rot_d  = cmd_rot;
                    cnt_d  = cmd_count;
                    data_d = cmd_data;
                    if (cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR) begin
                        state_d = S_LOAD;
                    end else if (cmd_count != '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                if (!halt) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready     = 1'b0;
        reg_ctrl      = CTRL_HOLD;
        reg_en        = 1'b0;
        reg_s_in      = 1'b0;
        ser_out       = 1'b0;
        ser_out_valid = 1'b0;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_LOAD: begin
                reg_ctrl = CTRL_LOAD;
                reg_en   = 1'b1;
            end
            S_SHIFT: begin
                // In rotate mode the bit leaving the register is fed straight back in.
                ser_out  = out_bit;
                reg_s_in = rot_q ? out_bit : ser_in;
                if (!halt) begin
                    reg_en        = 1'b1;
                    reg_ctrl      = shl_dir ? CTRL_SHL : CTRL_SHR;
                    ser_out_valid = 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign reg_d = data_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: directed and random commands against a bit-level reference
// of each command's outcome, with a behavioural stand-in for the shift register.
`timescale 1ns/1ps
module tb_shift_reg_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_rot = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             halt = 1'b0;
    logic             ser_in = 1'b0;
    logic [WIDTH-1:0] reg_q;
    logic [1:0]       reg_ctrl;
    logic             reg_en;
    logic             reg_s_in;
    logic [WIDTH-1:0] reg_d;
    logic             ser_out;
    logic             ser_out_valid;
    logic             done;
    logic             busy;

    logic [WIDTH-1:0] plant_q = 8'h00;
    logic [WIDTH-1:0] held_q;
    int               checks = 0;
    int               errors = 0;

    shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rot(cmd_rot),
        .cmd_count(cmd_count), .cmd_data(cmd_data), .halt(halt), .ser_in(ser_in),
        .reg_q(reg_q), .reg_ctrl(reg_ctrl), .reg_en(reg_en), .reg_s_in(reg_s_in),
        .reg_d(reg_d), .ser_out(ser_out), .ser_out_valid(ser_out_valid),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Universal shift register driven by the sequencer.
    assign reg_q = plant_q;
    always @(posedge clk) begin
        if (reg_en) begin
            case (reg_ctrl)
                2'b01:   plant_q <= {plant_q[WIDTH-2:0], reg_s_in};
                2'b10:   plant_q <= reg_d;
                2'b11:   plant_q <= {reg_s_in, plant_q[WIDTH-1:1]};
                default: plant_q <= plant_q;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'h1);
        chk({tag, "_ctrl"}, 32'(reg_ctrl), 32'h0);
        chk({tag, "_en"}, 32'(reg_en), 32'h0);
        chk({tag, "_s_in"}, 32'(reg_s_in), 32'h0);
        chk({tag, "_d"}, 32'(reg_d), 32'h0);
        chk({tag, "_ser_out"}, 32'(ser_out), 32'h0);
        chk({tag, "_valid"}, 32'(ser_out_valid), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Issue one command from IDLE and follow it to completion. The expected serial stream and
    // final register value are worked out up front from the command's meaning alone.
    task automatic run_cmd(input logic [1:0] op, input logic rot, input logic [3:0] cnt,
                           input logic [7:0] data, input bit fill_zero,
                           input int halt_at, input int halt_len, input int halt_pct);
        bit       is_load, shl, h;
        int       n, nh, hseen, idx, cycles;
        logic [7:0] v;
        logic     out_b, fill_b;
        logic     exp_out[16];
        logic     exp_fill[16];
        is_load = (op == 2'b00) || (op == 2'b11);
        shl     = (op == 2'b01);
        n       = (op == 2'b00) ? 0 : int'(cnt);
        v       = is_load ? data : plant_q;
        for (int i = 0; i < n; i++) begin
            out_b  = shl ? v[7] : v[0];
            fill_b = rot ? out_b : (fill_zero ? 1'b0 : 1'($urandom));
            exp_out[i]  = out_b;
            exp_fill[i] = fill_b;
            v = shl ? {v[6:0], fill_b} : {fill_b, v[7:1]};
        end

        chk("idle_ready", 32'(cmd_ready), 32'h1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rot   = rot;
        cmd_count = cnt;
        cmd_data  = data;
        @(posedge clk); #1;
        cycles = 1;
        nh     = 0;
        hseen  = 0;
        idx    = 0;
        // Keep offering a different command while busy; it must not be taken.
        cmd_op    = 2'($urandom);
        cmd_rot   = 1'($urandom);
        cmd_count = 4'($urandom);
        cmd_data  = 8'($urandom);

        if (is_load) begin
            halt   = 1'($urandom);
            ser_in = 1'($urandom);
            #1;
            chk("load_ctrl", 32'(reg_ctrl), 32'h2);
            chk("load_en", 32'(reg_en), 32'h1);
            chk("load_d", 32'(reg_d), 32'(data));
            chk("load_busy", 32'(busy), 32'h1);
            chk("load_ready", 32'(cmd_ready), 32'h0);
            @(posedge clk); #1;
            cycles++;
        end

        while (idx < n && cycles < 200) begin
            h = 1'b0;
            if (idx == halt_at && hseen < halt_len) begin
                h = 1'b1;
                hseen++;
            end else if (halt_pct > 0 && $urandom_range(0, 99) < halt_pct) begin
                h = 1'b1;
            end
            halt   = h;
            ser_in = rot ? 1'($urandom) : exp_fill[idx];
            #1;
            chk("shift_busy", 32'(busy), 32'h1);
            chk("shift_ready", 32'(cmd_ready), 32'h0);
            chk("shift_done", 32'(done), 32'h0);
            chk("shift_d", 32'(reg_d), 32'(data));
            if (h) begin
                nh++;
                chk("halt_en", 32'(reg_en), 32'h0);
                chk("halt_ctrl", 32'(reg_ctrl), 32'h0);
                chk("halt_valid", 32'(ser_out_valid), 32'h0);
            end else begin
                chk("shift_en", 32'(reg_en), 32'h1);
                chk("shift_ctrl", 32'(reg_ctrl), shl ? 32'h1 : 32'h3);
                chk("shift_valid", 32'(ser_out_valid), 32'h1);
                chk("shift_ser_out", 32'(ser_out), 32'(exp_out[idx]));
                chk("shift_s_in", 32'(reg_s_in), 32'(exp_fill[idx]));
                idx++;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (idx < n) chk("shift_timeout", 32'(idx), 32'(n));

        halt      = 1'($urandom);
        cmd_valid = 1'b0;
        #1;
        chk("done_pulse", 32'(done), 32'h1);
        chk("done_busy", 32'(busy), 32'h1);
        chk("done_en", 32'(reg_en), 32'h0);
        chk("done_ctrl", 32'(reg_ctrl), 32'h0);
        chk("done_ready", 32'(cmd_ready), 32'h0);
        chk("latency", 32'(cycles), 32'((is_load ? 1 : 0) + n + nh + 1));
        @(posedge clk); #1;
        halt = 1'b0;
        chk("post_done", 32'(done), 32'h0);
        chk("post_busy", 32'(busy), 32'h0);
        chk("post_ready", 32'(cmd_ready), 32'h1);
        chk("final_reg", 32'(plant_q), 32'(v));
    endtask

    initial begin
        #1;
        chk_reset_outputs("reset");
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("released");

        run_cmd(2'b00, 1'b0, 4'd0, 8'hA5, 1'b0, -1, 0, 0);
        chk("load_a5", 32'(plant_q), 32'hA5);

        run_cmd(2'b11, 1'b0, 4'd8, 8'hB4, 1'b1, -1, 0, 0);
        chk("load_shr_b4", 32'(plant_q), 32'h00);

        run_cmd(2'b00, 1'b0, 4'd0, 8'h81, 1'b0, -1, 0, 0);
        run_cmd(2'b01, 1'b1, 4'd3, 8'h3C, 1'b0, -1, 0, 0);
        chk("rotl_81", 32'(plant_q), 32'h0C);

        run_cmd(2'b10, 1'b0, 4'd4, 8'h5A, 1'b0, 2, 2, 0);
        run_cmd(2'b01, 1'b0, 4'd0, 8'h77, 1'b0, -1, 0, 0);

        // Asynchronous reset in the middle of a rotate.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_rot   = 1'b1;
        cmd_count = 4'd10;
        cmd_data  = 8'hC3;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_en", 32'(reg_en), 32'h1);
        held_q = plant_q;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(posedge clk); #1;
        chk("reset_keeps_reg", 32'(plant_q), 32'(held_q));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rerelease_ready", 32'(cmd_ready), 32'h1);

        for (int k = 0; k < 24; k++) begin
            run_cmd(2'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 1'b0, -1, 0,
                    int'($urandom_range(0, 30)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
